// File: rtl/set_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : set_mode_ctrl
// Description : Clock "set mode" controller. Three raw active-low buttons
//               (mode_set, inc, dec) are synchronized and debounced. mode_set
//               presses step NORMAL -> SET_S -> SET_M -> SET_H -> NORMAL. In
//               a SET state inc/dec presses produce single-cycle step pulses
//               for the selected field, with hold-to-auto-repeat. A blink
//               strobe marks the field being edited.
// Ports       : clk100khz            - system clock (100 kHz)
//               rst_n                - synchronous active-low reset
//               mode_set, inc, dec   - raw buttons, low = pressed
//               mode_flag[1:0]       - 0 normal, 1 sec, 2 min, 3 hours
//               inc_s..dec_h         - single-cycle field step pulses
//               sec_hold             - high while setting seconds
//               blink                - display blank strobe
// Options     : SET_TIMEOUT_EN - when defined, TIMEOUT_CYCLES cycles without
//               any press event in a SET state return the FSM to NORMAL.
// Revision    : 1.0 - initial release
// ============================================================================
module set_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000,
    parameter int BLINK_HALF      = 25000,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk100khz,
    input  logic       rst_n,
    input  logic       mode_set,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] mode_flag,
    output logic       inc_s,
    output logic       dec_s,
    output logic       inc_m,
    output logic       dec_m,
    output logic       inc_h,
    output logic       dec_h,
    output logic       sec_hold,
    output logic       blink
);

    localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_rp_n = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rp_w = (c_rp_n > 1) ? $clog2(c_rp_n) : 1;
    localparam int c_bl_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [c_db_w-1:0] c_db_max  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_rp_w-1:0] c_dly_max = c_rp_w'(REPEAT_DELAY - 1);
    localparam logic [c_rp_w-1:0] c_per_max = c_rp_w'(REPEAT_PERIOD - 1);
    localparam logic [c_bl_w-1:0] c_bl_max  = c_bl_w'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SET_S  = 2'd1,
        SET_M  = 2'd2,
        SET_H  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button front end: index 0 = mode_set, 1 = inc, 2 = dec
    // ------------------------------------------------------------------
    logic [2:0] w_raw;
    logic [2:0] w_ev;      // press event, high in the cycle the debounced level falls
    logic [2:1] w_deb;     // debounced inc/dec levels, 0 = pressed
    logic [1:0] r_warm;    // marks when the synchronizers hold real samples

    assign w_raw = {dec, inc, mode_set};

    always_ff @(posedge clk100khz) begin
        if (!rst_n) begin
            r_warm <= 2'b00;
        end else begin
            r_warm <= {r_warm[0], 1'b1};
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic              r_sync1;
        logic              r_sync2;
        logic              r_deb;
        logic              r_armed;
        logic              r_ev;
        logic [c_db_w-1:0] r_cnt;

        always_ff @(posedge clk100khz) begin
            if (!rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b1;
                r_armed <= 1'b0;
                r_ev    <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[b];
                r_sync2 <= r_sync1;
                r_ev    <= 1'b0;
                // A button held through reset must be seen released before
                // its next fall counts as a press.
                if (r_warm[1] && r_sync2) begin
                    r_armed <= 1'b1;
                end
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_max) begin
                    r_cnt <= '0;
                    r_deb <= r_sync2;
                    r_ev  <= ~r_sync2 & r_armed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_ev[b] = r_ev;

        if (b != 0) begin : g_lvl
            assign w_deb[b] = r_deb;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_timeout;
    logic   w_mode_chg;

`ifdef SET_TIMEOUT_EN
    localparam int c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [c_to_w-1:0] r_to_cnt;

    assign w_timeout = (r_state != NORMAL) && (r_to_cnt == c_to_max) && !(|w_ev);

    always_ff @(posedge clk100khz) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == NORMAL) || (|w_ev) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    // Timeout length has no meaning without the inactivity counter.
    localparam int c_timeout_unused = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk100khz) begin
        if (!rst_n) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ev[0]) begin
            case (r_state)
                NORMAL:  w_state_nxt = SET_S;
                SET_S:   w_state_nxt = SET_M;
                SET_M:   w_state_nxt = SET_H;
                default: w_state_nxt = NORMAL;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = NORMAL;
        end
    end

    assign w_mode_chg = (w_state_nxt != r_state);

    // ------------------------------------------------------------------
    // Step pulses and auto-repeat
    // ------------------------------------------------------------------
    logic              r_rep_act;   // a held button is eligible for repeats
    logic              r_rep_dec;   // repeating button: 0 = inc, 1 = dec
    logic              r_rep_per;   // 0 = waiting initial delay, 1 = periodic
    logic [c_rp_w-1:0] r_rep_cnt;
    logic [5:0]        r_pulse;     // {dec_h, inc_h, dec_m, inc_m, dec_s, inc_s}

    logic              w_rep_act_nxt;
    logic              w_rep_dec_nxt;
    logic              w_rep_per_nxt;
    logic [c_rp_w-1:0] w_rep_cnt_nxt;
    logic [5:0]        w_pulse_nxt;
    logic              w_step;
    logic              w_step_dec;
    logic              w_both;
    logic              w_held_rel;

    assign w_both     = ~w_deb[1] & ~w_deb[2];
    assign w_held_rel = r_rep_dec ? w_deb[2] : w_deb[1];

    always_comb begin
        w_rep_act_nxt = r_rep_act;
        w_rep_dec_nxt = r_rep_dec;
        w_rep_per_nxt = r_rep_per;
        w_rep_cnt_nxt = r_rep_cnt;
        w_step        = 1'b0;
        w_step_dec    = 1'b0;
        w_pulse_nxt   = '0;

        // A mode change, NORMAL, or both buttons down all kill any repeat;
        // only a fresh press event can start stepping again.
        if (w_mode_chg || (r_state == NORMAL) || w_both) begin
            w_rep_act_nxt = 1'b0;
            w_rep_per_nxt = 1'b0;
            w_rep_cnt_nxt = '0;
        end else if (w_ev[1] || w_ev[2]) begin
            w_step        = 1'b1;
            w_step_dec    = w_ev[2];
            w_rep_act_nxt = 1'b1;
            w_rep_dec_nxt = w_ev[2];
            w_rep_per_nxt = 1'b0;
            w_rep_cnt_nxt = '0;
        end else if (r_rep_act) begin
            if (w_held_rel) begin
                w_rep_act_nxt = 1'b0;
                w_rep_per_nxt = 1'b0;
                w_rep_cnt_nxt = '0;
            end else if (r_rep_cnt == (r_rep_per ? c_per_max : c_dly_max)) begin
                w_step        = 1'b1;
                w_step_dec    = r_rep_dec;
                w_rep_per_nxt = 1'b1;
                w_rep_cnt_nxt = '0;
            end else begin
                w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
        end

        if (w_step) begin
            case (r_state)
                SET_S:   w_pulse_nxt = w_step_dec ? 6'b000010 : 6'b000001;
                SET_M:   w_pulse_nxt = w_step_dec ? 6'b001000 : 6'b000100;
                SET_H:   w_pulse_nxt = w_step_dec ? 6'b100000 : 6'b010000;
                default: w_pulse_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk100khz) begin
        if (!rst_n) begin
            r_rep_act <= 1'b0;
            r_rep_dec <= 1'b0;
            r_rep_per <= 1'b0;
            r_rep_cnt <= '0;
            r_pulse   <= '0;
        end else begin
            r_rep_act <= w_rep_act_nxt;
            r_rep_dec <= w_rep_dec_nxt;
            r_rep_per <= w_rep_per_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Blink strobe: restarts high on entry to any SET state
    // ------------------------------------------------------------------
    logic              r_blink;
    logic [c_bl_w-1:0] r_bl_cnt;

    always_ff @(posedge clk100khz) begin
        if (!rst_n) begin
            r_blink  <= 1'b0;
            r_bl_cnt <= '0;
        end else if (w_mode_chg) begin
            r_blink  <= (w_state_nxt != NORMAL);
            r_bl_cnt <= '0;
        end else if (r_state == NORMAL) begin
            r_blink  <= 1'b0;
            r_bl_cnt <= '0;
        end else if (r_bl_cnt == c_bl_max) begin
            r_blink  <= ~r_blink;
            r_bl_cnt <= '0;
        end else begin
            r_bl_cnt <= r_bl_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mode_flag = r_state;
    assign sec_hold  = (r_state == SET_S);
    assign blink     = r_blink;
    assign inc_s     = r_pulse[0];
    assign dec_s     = r_pulse[1];
    assign inc_m     = r_pulse[2];
    assign dec_m     = r_pulse[3];
    assign inc_h     = r_pulse[4];
    assign dec_h     = r_pulse[5];

endmodule
`default_nettype wire

// File: tb/tb_set_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_mode_ctrl
// Description : Directed self-checking bench for set_mode_ctrl. Expected step
//               pulses are queued with their due cycle when a button is
//               driven; a negedge monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_mode_ctrl;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int BH  = 8;
    localparam int TO  = 100;
    // raw edge -> 2 sync flops -> DB-cycle window -> registered pulse
    localparam int LAT = DB + 3;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic       clk100khz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       mode_set  = 1'b1;
    logic       inc       = 1'b1;
    logic       dec       = 1'b1;
    logic [1:0] mode_flag;
    logic       inc_s, dec_s, inc_m, dec_m, inc_h, dec_h;
    logic       sec_hold;
    logic       blink;

    int         cyc      = 0;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    logic [1:0] cur_mode = 2'd0;
    exp_t       sb[$];
    exp_t       m_e;
    logic [5:0] m_obs;
    logic [5:0] m_exp;

    set_mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .BLINK_HALF      (BH),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .mode_set  (mode_set),
        .inc       (inc),
        .dec       (dec),
        .mode_flag (mode_flag),
        .inc_s     (inc_s),
        .dec_s     (dec_s),
        .inc_m     (inc_m),
        .dec_m     (dec_m),
        .inc_h     (inc_h),
        .dec_h     (dec_h),
        .sec_hold  (sec_hold),
        .blink     (blink)
    );

    always #5 clk100khz = ~clk100khz;

    always @(posedge clk100khz) cyc <= cyc + 1;

    // Pulse monitor: every cycle the six pulses must equal the queued
    // expectation for that cycle, or all zero when nothing is due.
    always @(negedge clk100khz) begin
        if (mon_en) begin
            m_obs = {dec_h, inc_h, dec_m, inc_m, dec_s, inc_s};
            m_exp = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                m_e   = sb.pop_front();
                m_exp = m_e.vec;
            end
            n_assert++;
            assert (m_obs === m_exp) else begin
                n_fail++;
                $error("FAIL pulses@%0d: observed %b expected %b", cyc, m_obs, m_exp);
            end
            n_assert++;
            assert ($countones(m_obs) <= 1) else begin
                n_fail++;
                $error("FAIL onehot@%0d: observed %b expected at most one bit", cyc, m_obs);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk100khz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int t, input logic [5:0] v);
        exp_t e;
        e.cyc = t;
        e.vec = v;
        sb.push_back(e);
    endtask

    // One mode_set press held 10 cycles; checks the step lands exactly
    // LAT cycles after the press, plus sec_hold and the blink phase.
    task automatic mode_press(input logic [1:0] exp_mode);
        mode_set = 1'b0;
        tick(LAT - 1);
        check("mode_before", 32'(mode_flag), 32'(cur_mode));
        tick(1);
        check("mode_after", 32'(mode_flag), 32'(exp_mode));
        check("sec_hold", 32'(sec_hold), 32'(exp_mode == 2'd1));
        check("blink_entry", 32'(blink), 32'(exp_mode != 2'd0));
        tick(3);
        mode_set = 1'b1;
        tick(BH - 4);
        check("blink_last_hi", 32'(blink), 32'(exp_mode != 2'd0));
        tick(1);
        check("blink_first_lo", 32'(blink), 32'd0);
        tick(5);
        cur_mode = exp_mode;
    endtask

    initial begin
        int n;
        int t;

        // Reset state
        tick(3);
        check("rst_mode", 32'(mode_flag), 32'd0);
        check("rst_pulses", 32'({dec_h, inc_h, dec_m, inc_m, dec_s, inc_s}), 32'd0);
        check("rst_sec_hold", 32'(sec_hold), 32'd0);
        check("rst_blink", 32'(blink), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(5);

        // Mode sequence 1, 2, 3, 0
        mode_press(2'd1);
        mode_press(2'd2);
        mode_press(2'd3);
        mode_press(2'd0);

        // inc in NORMAL: nothing queued, so any pulse is flagged
        inc = 1'b0;
        tick(10);
        inc = 1'b1;
        tick(15);
        check("normal_mode", 32'(mode_flag), 32'd0);

        // Mode 2, inc held 40 cycles: initial pulse then auto-repeat
        mode_press(2'd1);
        mode_press(2'd2);
        n   = cyc;
        inc = 1'b0;
        t   = n + LAT;
        push(t, 6'b000100);
        t   = t + RD;
        push(t, 6'b000100);
        for (int k = 0; k < 3; k++) begin
            t = t + RP;
            push(t, 6'b000100);
        end
        tick(40);
        inc = 1'b1;
        tick(20);

        // Mode 1, bouncing dec then held: one pulse after the stable window
        mode_press(2'd3);
        mode_press(2'd0);
        mode_press(2'd1);
        for (int i = 0; i < 6; i++) begin
            dec = i[0];
            tick(2);
        end
        dec = 1'b0;
        push(cyc + LAT, 6'b000010);
        tick(18);
        dec = 1'b1;
        tick(15);

        // Mode and inc pressed together: mode wins, held inc stays silent
        mode_set = 1'b0;
        inc      = 1'b0;
        tick(LAT - 1);
        check("prio_before", 32'(mode_flag), 32'd1);
        tick(1);
        check("prio_after", 32'(mode_flag), 32'd2);
        cur_mode = 2'd2;
        tick(3);
        mode_set = 1'b1;
        tick(27);
        inc = 1'b1;
        tick(15);

        // Mode 3, inc and dec both held, release dec, then re-press inc
        mode_press(2'd3);
        inc = 1'b0;
        dec = 1'b0;
        tick(30);
        dec = 1'b1;
        tick(20);
        inc = 1'b1;
        tick(10);
        inc = 1'b0;
        push(cyc + LAT, 6'b010000);
        tick(5);
        inc = 1'b1;
        tick(15);

        // Inactivity in mode 1
        mode_press(2'd0);
        mode_press(2'd1);
        tick(TO - 1 - (20 - LAT));
        check("idle_mode_pre", 32'(mode_flag), 32'd1);
        check("idle_blink_pre", 32'(blink), 32'd1);
        tick(1);
`ifdef SET_TIMEOUT_EN
        check("timeout_mode", 32'(mode_flag), 32'd0);
        check("timeout_blink", 32'(blink), 32'd0);
        cur_mode = 2'd0;
        tick(5);
        mode_press(2'd1);
        mode_press(2'd2);
`else
        check("no_timeout_mode", 32'(mode_flag), 32'd1);
        check("no_timeout_blink", 32'(blink), 32'd1);
        tick(5);
        mode_press(2'd2);
`endif

        // Reset while inc is held in mode 2
        n   = cyc;
        inc = 1'b0;
        push(n + LAT, 6'b000100);
        tick(15);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_mode", 32'(mode_flag), 32'd0);
        check("midrst_blink", 32'(blink), 32'd0);
        check("midrst_sec_hold", 32'(sec_hold), 32'd0);
        cur_mode = 2'd0;
        tick(5);
        mode_press(2'd1);
        mode_press(2'd2);
        tick(30);
        inc = 1'b1;
        tick(15);
        inc = 1'b0;
        push(cyc + LAT, 6'b000100);
        tick(5);
        inc = 1'b1;
        tick(20);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/set_mode_ctrl.md
SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEBOUNCE_CYCLES, 2000, cycles a raw button level must stay stable before it is accepted.
- REPEAT_DELAY, 50000, cycles a button is held before auto-repeat starts.
- REPEAT_PERIOD, 10000, cycles between auto-repeat pulses.
- BLINK_HALF, 25000, half-period of blink, in cycles.
- TIMEOUT_CYCLES, 1000000, inactivity limit in set mode, in cycles.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk100khz, in, 1, system clock, 100 kHz.
- rst_n, in, 1, reset; synchronous, active-low.
- mode_set, in, 1, raw mode button; asynchronous; low = pressed.
- inc, in, 1, raw increase button; asynchronous; low = pressed.
- dec, in, 1, raw decrease button; asynchronous; low = pressed.
- mode_flag, out, 2, 0 = normal, 1 = set seconds, 2 = set minutes, 3 = set hours.
- inc_s, dec_s, inc_m, dec_m, inc_h, dec_h, out, 1 each, single-cycle field step pulses.
- sec_hold, out, 1, high while mode_flag==1; the timebase SHALL suppress 1 Hz ticks while it is high.
- blink, out, 1, display blank strobe for the field being set.

Function
REQ-003 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-004 Debouncer: the debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-005 A press event SHALL be a debounced 1->0 transition; releases SHALL generate no event.
REQ-006 Mode FSM states: NORMAL(0) -> SET_S(1) -> SET_M(2) -> SET_H(3) -> NORMAL; it SHALL advance by exactly one state per mode_set press event.
REQ-007 In NORMAL, inc and dec events SHALL be ignored and all six pulse outputs SHALL stay 0.
REQ-008 In a SET state, an inc (dec) press event SHALL assert the selected field's inc_x (dec_x) for exactly one cycle, in the cycle after the debounced edge.
REQ-009 Auto-repeat: while the same button stays held, the first repeat pulse SHALL occur REPEAT_DELAY cycles after the initial pulse, then one pulse every REPEAT_PERIOD cycles until release.
REQ-010 While inc and dec are both debounced-pressed, no pulses SHALL be issued and the repeat counter SHALL be cleared; after one is released, the remaining held button SHALL NOT pulse until it is released and pressed again.
REQ-011 A mode change while inc/dec is held SHALL clear the repeat counter; the held button SHALL NOT pulse in the new state until re-pressed.
REQ-012 A mode event and an inc/dec event in the same cycle: the mode change SHALL take priority and the inc/dec event SHALL be dropped.
REQ-013 At most one of the six pulse outputs SHALL be high in any cycle.
REQ-014 blink SHALL toggle every BLINK_HALF cycles in SET states and SHALL restart high on every mode change; in NORMAL, blink SHALL be 0 and its counter held at 0.
REQ-015 All counters SHALL saturate or reload; none SHALL wrap through zero.
REQ-016 Counter widths SHALL be $clog2 of their parameter.

Reset
REQ-017 With rst_n low at a clock edge, the block SHALL set: mode_flag=0; all pulse outputs, sec_hold and blink = 0; debounced levels = 1 (released); all counters = 0.
REQ-018 Reset mid-press SHALL NOT emit a press event when rst_n deasserts while a button is held; the debouncer SHALL first see the released level.

Configuration
REQ-019 With macro SET_TIMEOUT_EN defined: in any SET state, TIMEOUT_CYCLES consecutive cycles with no press event SHALL return the FSM to NORMAL; any press event SHALL restart the count.
REQ-020 Without SET_TIMEOUT_EN: the FSM SHALL stay in a SET state indefinitely; the timeout counter SHALL NOT be synthesized.

Verification
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8, TIMEOUT_CYCLES=100.
REQ-021 Four mode_set presses, each held 10 cycles -> mode_flag sequence 1, 2, 3, 0; sec_hold high only while mode_flag==1.
REQ-022 Mode 2, inc held low for 40 cycles -> inc_m pulses at press+1, +21, +26, +31, +36 relative; no other pulses.
REQ-023 Mode 1, dec toggled every 2 cycles for 12 cycles, then held low -> exactly one dec_s pulse, 1 cycle after the first stable 4-cycle window.
REQ-024 Mode 3, inc and dec both held low; release dec -> zero pulses throughout; inc_h pulses only after inc is released and pressed again.
REQ-025 With SET_TIMEOUT_EN defined, mode 1 with no presses -> mode_flag returns to 0 after 100 cycles; blink forced to 0 in the same cycle.
REQ-026 rst_n low for 1 cycle while inc is held in mode 2 -> mode_flag=0 and no inc_m pulse before release and re-press.
